vga_plot_arbiter: RTL and testbench

- Shares the single VGA adapter plot port (160x120, 3-bit colour) among NUM_REQ sprite draw/erase engines, e.g. player, obstacles and score.
- Each engine requests the port, streams a burst of pixels, and marks the last one.
- The block grants the port round-robin and registers the selected pixel onto the adapter.
- It sits between the per-object sequencing FSMs and the VGA adapter.

---
 rtl/vga_plot_pkg.sv | 12 +
 rtl/vga_plot_arbiter_if.sv | 30 +++
 rtl/plot_rr_picker.sv | 28 ++
 rtl/vga_plot_arbiter.sv | 103 ++++++++++
 tb/tb_vga_plot_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_plot_pkg.sv
// Shared defaults and state encoding for the VGA plot-port arbiter family.
package vga_plot_pkg;
    localparam int PLOT_X_W = 8;   // 160 columns
    localparam int PLOT_Y_W = 7;   // 120 rows
    localparam int PLOT_C_W = 3;   // 3-bit colour

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;
endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus plus the adapter-side plot port of the arbiter.
interface vga_plot_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = vga_plot_pkg::PLOT_X_W,
    parameter int Y_W     = vga_plot_pkg::PLOT_Y_W,
    parameter int C_W     = vga_plot_pkg::PLOT_C_W
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     px_valid;
    logic [NUM_REQ-1:0]     last;
    logic [NUM_REQ*X_W-1:0] x_in;
    logic [NUM_REQ*Y_W-1:0] y_in;
    logic [NUM_REQ*C_W-1:0] colour_in;
    logic [NUM_REQ-1:0]     grant;
    logic [X_W-1:0]         x_out;
    logic [Y_W-1:0]         y_out;
    logic [C_W-1:0]         colour_out;
    logic                   plot_out;
    logic                   busy;
    logic                   wd_timeout;

    modport master (
        output req, px_valid, last, x_in, y_in, colour_in,
        input  grant, x_out, y_out, colour_out, plot_out, busy, wd_timeout
    );
    modport slave (
        input  req, px_valid, last, x_in, y_in, colour_in,
        output grant, x_out, y_out, colour_out, plot_out, busy, wd_timeout
    );
endinterface

// File: rtl/plot_rr_picker.sv
// Combinational round-robin picker: first set req bit above rr_ptr, wrapping.
module plot_rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      winner_idx,
    output logic               any
);
    logic [IW-1:0] idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner_idx = idx;
            end
        end
        winner[winner_idx] = any;
    end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA adapter plot port; registers the owner's pixel.
// Optional idle watchdog on the owner is enabled with PLOT_ARB_WATCHDOG_EN.
module vga_plot_arbiter
    import vga_plot_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int X_W       = PLOT_X_W,
    parameter int Y_W       = PLOT_Y_W,
    parameter int C_W       = PLOT_C_W,
    parameter int MAX_BURST = 256,
    parameter int WD_CYCLES = 64
) (
    input logic              clk,
    input logic              reset_n,
    vga_plot_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t             state, state_nx;
    logic [IW-1:0]      rr_ptr, owner, pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic [BW-1:0]      burst_cnt;
    logic               own_req, own_pv, own_last, accept, burst_end, wd_fire;

    plot_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .rr_ptr     (rr_ptr),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    assign own_req  = bus.req[owner];
    assign own_pv   = bus.px_valid[owner];
    assign own_last = bus.last[owner];
    // A dropped req aborts the burst, so a pixel in that cycle is discarded.
    assign accept    = (state == S_GRANT) && own_req && own_pv;
    assign burst_end = accept && (own_last || burst_cnt == BW'(MAX_BURST - 1));
    assign bus.busy  = (state == S_GRANT);

`ifdef PLOT_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);
    logic [WW-1:0] idle_cnt;

    assign wd_fire = (state == S_GRANT) && own_req && !own_pv &&
                     idle_cnt == WW'(WD_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!reset_n || state != S_GRANT || own_pv) idle_cnt <= '0;
        else                                        idle_cnt <= idle_cnt + 1'b1;
    end
`else
    // No watchdog: an owner may stall forever.
    assign wd_fire = 1'b0 && (WD_CYCLES > 0);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (pick_any) state_nx = S_GRANT;
            S_GRANT:   if (!own_req || burst_end || wd_fire) state_nx = S_RELEASE;
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            rr_ptr         <= IW'(NUM_REQ - 1);
            owner          <= '0;
            burst_cnt      <= '0;
            bus.grant      <= '0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
            bus.plot_out   <= 1'b0;
            bus.wd_timeout <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.plot_out   <= accept;
            bus.wd_timeout <= wd_fire;
            if (accept) begin
                bus.x_out      <= bus.x_in[int'(owner)*X_W +: X_W];
                bus.y_out      <= bus.y_in[int'(owner)*Y_W +: Y_W];
                bus.colour_out <= bus.colour_in[int'(owner)*C_W +: C_W];
                burst_cnt      <= burst_cnt + 1'b1;
            end
            case (state)
                S_IDLE: if (pick_any) begin
                    owner     <= pick_idx;
                    bus.grant <= pick_oh;
                    burst_cnt <= '0;
                end
                S_GRANT:   if (state_nx == S_RELEASE) bus.grant <= '0;
                S_RELEASE: rr_ptr <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed + randomized bench for vga_plot_arbiter against a transaction-level model.
module tb_vga_plot_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int MB = 256;
    localparam int WD = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) bus ();

    vga_plot_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW),
                       .MAX_BURST(MB), .WD_CYCLES(WD)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;
    // requester scripts
    int rem[N], sent[N], start_at[N], drop_at[N], stall_at[N], dens[N], plots[N];
    logic [XW-1:0] bx[N];
    logic [YW-1:0] by[N];
    logic [CW-1:0] bc[N];
    // model: who owns the port, who was served last, dead cycles before next pick
    int m_owner = -1, m_last = N - 1, m_dead = 0, m_cnt = 0, m_idle = 0, nplots = 0, n_wd = 0;
    int e_grant = 0, e_plot = 0, e_x = 0, e_y = 0, e_c = 0, e_busy = 0, e_wd = 0;
    int gseq[$];
    int xq[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic setup();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; sent[i] = 0; start_at[i] = 0; drop_at[i] = -1; stall_at[i] = -1;
            dens[i] = 100; plots[i] = 0;
            bx[i] = XW'($urandom); by[i] = YW'($urandom); bc[i] = CW'($urandom);
        end
        gseq.delete(); xq.delete(); nplots = 0; n_wd = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit own, r, v, l;
            own = (m_owner == i);
            r = (rem[i] > 0) && (cyc >= start_at[i]);
            v = $urandom_range(1);
            l = $urandom_range(1);
            if (own && drop_at[i] == sent[i]) r = 1'b0;
            if (own) begin
                v = (rem[i] > 0) && (sent[i] != stall_at[i]) && ($urandom_range(99) < dens[i]);
                if (!r) v = 1'b1;
                l = v ? (rem[i] == 1) : $urandom_range(1);
                bus.x_in[i*XW +: XW]      = bx[i] + XW'(sent[i]);
                bus.y_in[i*YW +: YW]      = by[i];
                bus.colour_in[i*CW +: CW] = bc[i];
            end else begin
                bus.x_in[i*XW +: XW]      = XW'($urandom);
                bus.y_in[i*YW +: YW]      = YW'($urandom);
                bus.colour_in[i*CW +: CW] = CW'($urandom);
            end
            bus.req[i] = r; bus.px_valid[i] = v; bus.last[i] = l;
        end
    endtask

    task automatic release_port(int o);
        m_last = o; m_owner = -1; m_dead = 1;
    endtask

    task automatic model();
        int o;
        e_plot = 0; e_wd = 0;
        o = m_owner;
        if (!reset_n) begin
            m_owner = -1; m_last = N - 1; m_dead = 0; e_x = 0; e_y = 0; e_c = 0;
        end else if (o >= 0) begin
            if (!bus.req[o]) begin
                rem[o] = 0;
                release_port(o);
            end else if (bus.px_valid[o]) begin
                e_plot = 1;
                e_x = bus.x_in[o*XW +: XW]; e_y = bus.y_in[o*YW +: YW]; e_c = bus.colour_in[o*CW +: CW];
                m_cnt++; m_idle = 0; sent[o]++; rem[o]--; plots[o]++; nplots++;
                if (bus.last[o] || m_cnt == MB) release_port(o);
            end else begin
                m_idle++;
`ifdef PLOT_ARB_WATCHDOG_EN
                if (m_idle == WD) begin
                    release_port(o);
                    e_wd = 1;
                end
`endif
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (bus.req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int w;
                w = (m_last + k) % N;
                if (m_owner < 0 && bus.req[w]) begin
                    m_owner = w; m_cnt = 0; m_idle = 0; gseq.push_back(w);
                end
            end
        end
        e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_busy  = (m_owner >= 0);
    endtask

    task automatic cycle();
        drive();
        model();
        @(posedge clk);
        #1;
        cyc++;
        chk("grant", bus.grant, e_grant);
        chk("plot_out", bus.plot_out, e_plot);
        chk("x_out", bus.x_out, e_x);
        chk("y_out", bus.y_out, e_y);
        chk("colour_out", bus.colour_out, e_c);
        chk("busy", bus.busy, e_busy);
        chk("wd_timeout", bus.wd_timeout, e_wd);
        if (bus.plot_out) xq.push_back(int'(bus.x_out));
        if (bus.wd_timeout) n_wd++;
    endtask

    function automatic bit all_done();
        int s = 0;
        for (int i = 0; i < N; i++) s += rem[i];
        return (s == 0) && (m_owner < 0) && (m_dead == 0);
    endfunction

    task automatic drain(string tag, int budget);
        int n = 0;
        while (!all_done() && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, all_done(), 1);
    endtask

    initial begin
        int total, n;
        setup();
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;

        // all four request together, 3 pixels each
        setup();
        for (int i = 0; i < N; i++) rem[i] = 3;
        drain("s1", 100);
        chk("s1_plots", nplots, 12);
        chk("s1_grants", gseq.size(), 4);
        if (gseq.size() == 4) for (int k = 0; k < 4; k++) chk("s1_order", gseq[k], k);

        // single requester with gaps and fixed coordinates
        setup();
        rem[2] = 5; dens[2] = 40; bx[2] = 8'd10; by[2] = 7'd20; bc[2] = 3'd3;
        drain("s2", 200);
        chk("s2_count", xq.size(), 5);
        if (xq.size() == 5) for (int k = 0; k < 5; k++) chk("s2_x", xq[k], 10 + k);

        // 300-pixel stream forces a release at MAX_BURST
        setup();
        rem[1] = 300;
        drain("s3", 400);
        chk("s3_plots", plots[1], 300);
        chk("s3_grants", gseq.size(), 2);
        if (gseq.size() == 2) chk("s3_regrant", gseq[1], 1);

        // requester 3 aborts after 7 pixels while 0 waits
        setup();
        rem[3] = 20; drop_at[3] = 7; rem[0] = 3; start_at[0] = cyc + 3;
        drain("s4", 200);
        chk("s4_plots3", plots[3], 7);
        chk("s4_grants", gseq.size(), 2);
        if (gseq.size() == 2) begin
            chk("s4_first", gseq[0], 3);
            chk("s4_next", gseq[1], 0);
        end

        // reset in the middle of a burst
        setup();
        rem[2] = 10;
        n = 0;
        while (!(m_owner == 2 && sent[2] >= 3) && n < 50) begin
            cycle();
            n++;
        end
        chk("s5_reached", (m_owner == 2) && (sent[2] >= 3), 1);
        reset_n = 1'b0;
        cycle();
        chk("s5_rst_plot", bus.plot_out, 0);
        chk("s5_rst_grant", bus.grant, 0);
        reset_n = 1'b1;
        setup();
        rem[0] = 2; rem[3] = 2;
        drain("s5", 100);
        chk("s5_grants", gseq.size(), 2);
        if (gseq.size() == 2) chk("s5_first", gseq[0], 0);

        // randomized traffic rounds
        for (int r = 0; r < 4; r++) begin
            setup();
            total = 0;
            for (int i = 0; i < N; i++) begin
                rem[i] = $urandom_range(12);
                dens[i] = $urandom_range(100, 30);
                start_at[i] = cyc + $urandom_range(6);
                total += rem[i];
            end
            drain("rnd", 1000);
            chk("rnd_plots", nplots, total);
        end

`ifdef PLOT_ARB_WATCHDOG_EN
        // owner stalls after 2 pixels; watchdog hands the port to requester 1
        setup();
        rem[0] = 5; stall_at[0] = 2; rem[1] = 2; start_at[1] = cyc + 2;
        n = 0;
        while (!(rem[1] == 0 && m_owner < 0) && n < 400) begin
            cycle();
            n++;
        end
        chk("wd_served1", rem[1], 0);
        rem[0] = 0;
        drain("wd", 50);
        chk("wd_pulses", n_wd, 1);
        chk("wd_plots0", plots[0], 2);
        if (gseq.size() >= 2) chk("wd_next", gseq[1], 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
